my_topk_sort: RTL
=================

Name: my_topk_sort

Overview:
Parametrised streaming top-K selector, successor to the fixed 40-entry/top-4 my_sort block. It accepts NUM_IN unsigned samples one per accepted beat and keeps a K-deep sorted register list by parallel compare-and-shift insertion. It reports the K largest values (or K smallest, in min mode) with their stream indices. It sits after the column readout and feeds the blooming-detection logic.

Parameters:
DATA_W, 14, sample width (unsigned)
NUM_IN, 40, samples per sort pass
TOP_K, 4, number of retained results; elaboration error unless 1 <= TOP_K <= NUM_IN
IDX_W, $clog2(NUM_IN), derived localparam; width of sample index

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
sort_start  input  1  starts a pass; honoured only in IDLE
mode_min  input  1  sampled with sort_start; 0 = K largest, descending; 1 = K smallest, ascending
in_valid  input  1  in_data valid
in_ready  output  1  high only in LOAD
in_data  input  DATA_W  sample
sort_busy  output  1  high in LOAD and DONE
sort_finish  output  1  one-cycle pulse in DONE
sorted_data  output  TOP_K*DATA_W  packed results; slot 0 (LSBs) = best
sorted_idx  output  TOP_K*IDX_W  stream index (0-based) of each slot

Behaviour:
- Single clock, one clock domain. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; in_ready, sort_busy and sort_finish 0; all slots, slot-valid flags and indices 0; beat counter 0.
- FSM IDLE -> LOAD -> DONE -> IDLE.
- IDLE:
  - in_valid is ignored.
  - On sort_start: latch mode_min, clear all slot-valid flags, data and indices to 0, clear the counter, and go to LOAD next cycle.
- LOAD:
  - in_ready = 1. A beat is accepted when in_valid & in_ready.
  - The accepted sample gets index = counter; the counter then increments.
  - The NUM_IN-th accepted beat moves the FSM to DONE. in_ready drops in the following cycle.
  - sort_start is ignored throughout LOAD.
- Insertion, completed in the accept cycle:
  - p = count of valid slots whose value beats or ties the new sample, using > for max mode and < for min mode, unsigned.
  - If p < TOP_K: slots p..TOP_K-2 shift to p+1..TOP_K-1, the old slot TOP_K-1 is dropped, and the new sample is written to slot p with its valid flag set.
  - If p = TOP_K: the sample is discarded.
  - Ties resolve stably: the earlier index always ranks first.
- DONE: lasts exactly one cycle. sort_finish = 1, then the FSM returns to IDLE.
- Latency: sort_finish rises one cycle after the last accepted beat.
- Back-to-back: sort_start sampled in the DONE cycle is ignored. sort_start in the first IDLE cycle after DONE is honoured.
- Results: sorted_data and sorted_idx are registered and hold after finish until the next honoured sort_start clears them. During LOAD they reflect partial results.
- All slots are valid at finish because NUM_IN >= TOP_K.
- Reset mid-pass aborts immediately: outputs go to reset values and no sort_finish pulse is generated.

Decomposition:
- Package my_sort_pkg:
  - default DATA_W/NUM_IN/TOP_K constants
  - state enum (IDLE, LOAD, DONE)
  - mode encoding constants
  - IDX_W helper function
- Sub-module my_topk_insert: purely combinational. Takes the current slot arrays, valid flags, new sample/index and mode. Returns the next slot arrays.
- my_topk_sort owns the FSM, counter and registers.

Test Plan:
1. Defaults, mode_min=0, in_valid held high. Indices 0..38 carry 500+$random%100 and index 39 carries 800.
   -> slot0 = 800, idx 39; slots 1..3 are the top three of the random set, in descending order.
   -> With the start pulse in cycle t, sort_finish pulses exactly in cycle t+41 and lasts one cycle.
2. All 40 samples = 500 -> sorted_data all 500; sorted_idx = 0,1,2,3.
3. mode_min=1, sample i = 40-i -> sorted_data = 1,2,3,4; sorted_idx = 39,38,37,36.
4. in_valid toggled every other cycle, and sort_start pulsed during LOAD.
   -> Only accepted beats count; finish comes one cycle after the 40th accepted beat; the mid-LOAD start has no effect.
5. rst_n asserted after 20 beats -> sort_busy, in_ready, outputs 0 and no finish. A fresh pass with the test-1 data gives the test-1 result.
6. Two passes back-to-back, second start in the first IDLE cycle after DONE, second data = 0..39.
   -> Results clear on the start; the second pass returns 39,38,37,36 with idx 39,38,37,36.

Source files
------------

// File: rtl/my_sort_pkg.sv
// Shared constants, state encoding and helpers for the streaming top-K selector.
package my_sort_pkg;

  localparam int DEF_DATA_W = 14;
  localparam int DEF_NUM_IN = 40;
  localparam int DEF_TOP_K  = 4;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_MIN = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } sort_state_t;

  // Index width, never below one bit so a single-sample pass still elaborates.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/my_topk_insert.sv
// Combinational compare-and-shift insertion of one sample into a K-deep sorted list.
module my_topk_insert
  import my_sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = 6,
  parameter int TOP_K  = DEF_TOP_K
) (
  input  logic [TOP_K-1:0][DATA_W-1:0] slot_data,
  input  logic [TOP_K-1:0][IDX_W-1:0]  slot_idx,
  input  logic [TOP_K-1:0]             slot_valid,
  input  logic [DATA_W-1:0]            new_data,
  input  logic [IDX_W-1:0]             new_idx,
  input  logic                         mode_min,
  output logic [TOP_K-1:0][DATA_W-1:0] nxt_data,
  output logic [TOP_K-1:0][IDX_W-1:0]  nxt_idx,
  output logic [TOP_K-1:0]             nxt_valid
);

  // keep[k]: slot k ranks ahead of the new sample. Ties keep the older entry ahead,
  // which makes the ordering stable by stream index.
  logic [TOP_K-1:0]             keep;
  logic [TOP_K:0]               keep_ext;
  logic [TOP_K:0][DATA_W-1:0]   ext_data;
  logic [TOP_K:0][IDX_W-1:0]    ext_idx;
  logic [TOP_K:0]               ext_valid;

  always_comb begin
    for (int k = 0; k < TOP_K; k++) begin
      if (mode_min == MODE_MIN)
        keep[k] = slot_valid[k] && (slot_data[k] <= new_data);
      else
        keep[k] = slot_valid[k] && (slot_data[k] >= new_data);
    end
  end

  // Element k of the extended vectors is slot k-1; element 0 is the new sample.
  always_comb begin
    keep_ext  = {keep, 1'b1};
    ext_data  = {slot_data, new_data};
    ext_idx   = {slot_idx, new_idx};
    ext_valid = {slot_valid, 1'b1};
  end

  always_comb begin
    nxt_data  = slot_data;
    nxt_idx   = slot_idx;
    nxt_valid = slot_valid;
    for (int k = 0; k < TOP_K; k++) begin
      if (keep[k]) begin
        nxt_data[k]  = slot_data[k];
        nxt_idx[k]   = slot_idx[k];
        nxt_valid[k] = slot_valid[k];
      end else if (keep_ext[k]) begin
        nxt_data[k]  = new_data;
        nxt_idx[k]   = new_idx;
        nxt_valid[k] = 1'b1;
      end else begin
        nxt_data[k]  = ext_data[k];
        nxt_idx[k]   = ext_idx[k];
        nxt_valid[k] = ext_valid[k];
      end
    end
  end

endmodule

// File: rtl/my_topk_sort.sv
// Streaming top-K selector: IDLE/LOAD/DONE sequencer, beat counter and sorted result registers.
module my_topk_sort
  import my_sort_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_IN = DEF_NUM_IN,
  parameter int TOP_K  = DEF_TOP_K,
  localparam int IDX_W = idx_width(NUM_IN)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sort_start,
  input  logic                      mode_min,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  output logic                      sort_busy,
  output logic                      sort_finish,
  output logic [TOP_K*DATA_W-1:0]   sorted_data,
  output logic [TOP_K*IDX_W-1:0]    sorted_idx
);

  // state | meaning
  // IDLE  | waiting for sort_start; in_valid ignored
  // LOAD  | accepting NUM_IN beats, inserting each into the sorted list
  // DONE  | single-cycle sort_finish pulse, results held

  if (TOP_K < 1 || TOP_K > NUM_IN) begin : g_bad_cfg
    $error("my_topk_sort: TOP_K must lie in 1..NUM_IN");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);

  sort_state_t                 state;
  logic                        mode_q;
  logic [IDX_W-1:0]            cnt;
  logic [TOP_K-1:0][DATA_W-1:0] slot_data;
  logic [TOP_K-1:0][IDX_W-1:0]  slot_idx;
  logic [TOP_K-1:0]             slot_valid;

  logic [TOP_K-1:0][DATA_W-1:0] nxt_data;
  logic [TOP_K-1:0][IDX_W-1:0]  nxt_idx;
  logic [TOP_K-1:0]             nxt_valid;

  my_topk_insert #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W),
    .TOP_K  (TOP_K)
  ) u_insert (
    .slot_data  (slot_data),
    .slot_idx   (slot_idx),
    .slot_valid (slot_valid),
    .new_data   (in_data),
    .new_idx    (cnt),
    .mode_min   (mode_q),
    .nxt_data   (nxt_data),
    .nxt_idx    (nxt_idx),
    .nxt_valid  (nxt_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_q      <= MODE_MAX;
      cnt         <= '0;
      slot_data   <= '0;
      slot_idx    <= '0;
      slot_valid  <= '0;
      in_ready    <= 1'b0;
      sort_busy   <= 1'b0;
      sort_finish <= 1'b0;
    end else begin
      sort_finish <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (sort_start) begin
            mode_q     <= mode_min;
            cnt        <= '0;
            slot_data  <= '0;
            slot_idx   <= '0;
            slot_valid <= '0;
            in_ready   <= 1'b1;
            sort_busy  <= 1'b1;
            state      <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready) begin
            slot_data  <= nxt_data;
            slot_idx   <= nxt_idx;
            slot_valid <= nxt_valid;
            cnt        <= cnt + 1'b1;
            if (cnt == LAST_IDX) begin
              in_ready    <= 1'b0;
              sort_finish <= 1'b1;
              state       <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          sort_busy <= 1'b0;
          state     <= ST_IDLE;
        end
        default: begin
          in_ready  <= 1'b0;
          sort_busy <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign sorted_data = slot_data;
  assign sorted_idx  = slot_idx;

endmodule
